// File: rtl/lane_merge_sched_if.sv
// lane_merge_sched_if: bundles the lane inputs, the merged output handshake
// and the status flags of lane_merge_sched.
//   master : drives en, lane_in0/1, valid_in0/1 and ready_in; observes the outputs
//   slave  : the scheduler side; drives data_out, valid_out, full0/1 and overflow_err
// LANE_MERGE_CNT_EN adds word_cnt[15:0] (slave output).
interface lane_merge_sched_if #(
  parameter int DATA_W = 32
);
  logic              en;
  logic [DATA_W-1:0] lane_in0;
  logic              valid_in0;
  logic [DATA_W-1:0] lane_in1;
  logic              valid_in1;
  logic              ready_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              full0;
  logic              full1;
  logic              overflow_err;
`ifdef LANE_MERGE_CNT_EN
  logic [15:0]       word_cnt;

  modport master (
    output en, lane_in0, valid_in0, lane_in1, valid_in1, ready_in,
    input  data_out, valid_out, full0, full1, overflow_err, word_cnt
  );
  modport slave (
    input  en, lane_in0, valid_in0, lane_in1, valid_in1, ready_in,
    output data_out, valid_out, full0, full1, overflow_err, word_cnt
  );
`else
  modport master (
    output en, lane_in0, valid_in0, lane_in1, valid_in1, ready_in,
    input  data_out, valid_out, full0, full1, overflow_err
  );
  modport slave (
    input  en, lane_in0, valid_in0, lane_in1, valid_in1, ready_in,
    output data_out, valid_out, full0, full1, overflow_err
  );
`endif
endinterface

// File: rtl/lane_merge_sched.sv
// lane_merge_sched: re-merges two striped lanes into one word stream in strict
// lane0, lane1, lane0, ... order. Each lane is buffered in a FIFO_DEPTH-entry
// FIFO so the lanes may be skewed; the scheduler stalls on the expected lane.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low
//   bus   - lane_merge_sched_if.slave: en, lane_in0/1, valid_in0/1, ready_in in;
//           registered data_out/valid_out, full0/1, sticky overflow_err out
// Optional: define LANE_MERGE_CNT_EN for word_cnt[15:0] output handshake count.
module lane_merge_sched #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input logic               clk,
  input logic               reset,
  lane_merge_sched_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEL0 = 2'd1;
  localparam logic [1:0] SEL1 = 2'd2;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem0 [FIFO_DEPTH];
  logic [DATA_W-1:0] mem1 [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr0, rd0, wr1, rd1;
  logic [PTR_W:0]    cnt0, cnt1;
  logic [1:0]        state;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              ovf_q;

  logic full0, full1, push0, push1, drop0, drop1;
  logic exp1, head_ok, load, pop0, pop1;
  logic [DATA_W-1:0] head;

  // Full is judged on the registered count, so a same-cycle pop never
  // makes room for a write to a full lane.
  assign full0 = (cnt0 == DEPTH_C);
  assign full1 = (cnt1 == DEPTH_C);

  always_comb begin
    push0   = bus.en && bus.valid_in0 && !full0;
    push1   = bus.en && bus.valid_in1 && !full1;
    drop0   = bus.en && bus.valid_in0 && full0;
    drop1   = bus.en && bus.valid_in1 && full1;
    exp1    = (state == SEL1);
    head_ok = exp1 ? (cnt1 != '0) : (cnt0 != '0);
    // IDLE expects lane0 but never pops.
    load    = bus.en && (state != IDLE) && (!valid_q || bus.ready_in) && head_ok;
    pop0    = load && !exp1;
    pop1    = load && exp1;
    head    = exp1 ? mem1[rd1] : mem0[rd0];
  end

  always_ff @(posedge clk) begin
    if (push0) mem0[wr0] <= bus.lane_in0;
    if (push1) mem1[wr1] <= bus.lane_in1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr0     <= '0;
      rd0     <= '0;
      wr1     <= '0;
      rd1     <= '0;
      cnt0    <= '0;
      cnt1    <= '0;
      state   <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!bus.en) begin
      // Flush: data_out and overflow_err keep their values.
      wr0     <= '0;
      rd0     <= '0;
      wr1     <= '0;
      rd1     <= '0;
      cnt0    <= '0;
      cnt1    <= '0;
      state   <= IDLE;
      valid_q <= 1'b0;
    end else begin
      if (push0) wr0 <= wr0 + PTR_W'(1);
      if (pop0)  rd0 <= rd0 + PTR_W'(1);
      if (push1) wr1 <= wr1 + PTR_W'(1);
      if (pop1)  rd1 <= rd1 + PTR_W'(1);

      case ({push0, pop0})
        2'b10:   cnt0 <= cnt0 + (PTR_W + 1)'(1);
        2'b01:   cnt0 <= cnt0 - (PTR_W + 1)'(1);
        default: cnt0 <= cnt0;
      endcase
      case ({push1, pop1})
        2'b10:   cnt1 <= cnt1 + (PTR_W + 1)'(1);
        2'b01:   cnt1 <= cnt1 - (PTR_W + 1)'(1);
        default: cnt1 <= cnt1;
      endcase

      if (drop0 || drop1) ovf_q <= 1'b1;

      if (load) begin
        data_q  <= head;
        valid_q <= 1'b1;
      end else if (valid_q && bus.ready_in) begin
        valid_q <= 1'b0;
      end

      case (state)
        IDLE:    state <= SEL0;
        SEL0:    if (load) state <= SEL1;
        SEL1:    if (load) state <= SEL0;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data_out     = data_q;
  assign bus.valid_out    = valid_q;
  assign bus.full0        = full0;
  assign bus.full1        = full1;
  assign bus.overflow_err = ovf_q;

`ifdef LANE_MERGE_CNT_EN
  logic [15:0] wcnt;

  always_ff @(posedge clk) begin
    if (!reset || !bus.en) begin
      wcnt <= '0;
    end else if (valid_q && bus.ready_in) begin
      wcnt <= wcnt + 16'd1;
    end
  end

  assign bus.word_cnt = wcnt;
`endif

endmodule

// File: tb/tb_lane_merge_sched.sv
// Bench for lane_merge_sched: directed scenarios plus a randomized run, all
// checked against a queue-based model of the lane merge rules.
module tb_lane_merge_sched;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lane_merge_sched_if #(.DATA_W(DW)) bus ();

  lane_merge_sched #(
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH),
    .PTR_W     (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per lane, an alternating expected-lane flag.
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  bit          m_started;
  bit          m_exp1;
  bit          m_vout;
  bit          m_ovf;
  logic [31:0] m_dout;
`ifdef LANE_MERGE_CNT_EN
  logic [15:0] m_cnt;
`endif

  task automatic cyc(input bit r, input bit e, input bit v0, input logic [31:0] d0,
                     input bit v1, input logic [31:0] d1, input bit rdy);
    bit hs, f0, f1, ld;
    reset         = r;
    bus.en        = e;
    bus.valid_in0 = v0;
    bus.lane_in0  = d0;
    bus.valid_in1 = v1;
    bus.lane_in1  = d1;
    bus.ready_in  = rdy;
    @(posedge clk);
    if (!r) begin
      q0.delete(); q1.delete();
      m_started = 0; m_exp1 = 0; m_vout = 0; m_dout = '0; m_ovf = 0;
`ifdef LANE_MERGE_CNT_EN
      m_cnt = '0;
`endif
    end else if (!e) begin
      q0.delete(); q1.delete();
      m_started = 0; m_exp1 = 0; m_vout = 0;
`ifdef LANE_MERGE_CNT_EN
      m_cnt = '0;
`endif
    end else begin
      hs = m_vout && rdy;
      f0 = (q0.size() == DEPTH);
      f1 = (q1.size() == DEPTH);
      ld = m_started && (!m_vout || rdy) && (m_exp1 ? q1.size() > 0 : q0.size() > 0);
`ifdef LANE_MERGE_CNT_EN
      if (hs) m_cnt = m_cnt + 16'd1;
`endif
      if (ld) begin
        m_dout = m_exp1 ? q1.pop_front() : q0.pop_front();
        m_vout = 1;
        m_exp1 = !m_exp1;
      end else if (hs) begin
        m_vout = 0;
      end
      if (v0) begin
        if (f0) m_ovf = 1; else q0.push_back(d0);
      end
      if (v1) begin
        if (f1) m_ovf = 1; else q1.push_back(d1);
      end
      m_started = 1;
    end
    #1;
  endtask

  function automatic logic [35:0] dvec();
    return {bus.valid_out, bus.data_out, bus.full0, bus.full1, bus.overflow_err};
  endfunction

  function automatic logic [35:0] mvec();
    return {m_vout, m_dout, 1'(q0.size() == DEPTH), 1'(q1.size() == DEPTH), m_ovf};
  endfunction

  task automatic settle();
    cyc(1, 0, 0, '0, 0, '0, 1);
    cyc(1, 1, 0, '0, 0, '0, 1);
  endtask

  task automatic test_reset();
    cyc(0, 1, 1, $urandom, 1, $urandom, 1'($urandom_range(0, 1)));
    checks++;
    if (dvec() !== 36'h0) begin
      failures++;
      $display("FAIL reset_outputs dut=%h required=%h", dvec(), 36'h0);
    end
    checks++;
    if (dvec() !== mvec()) begin
      failures++;
      $display("FAIL reset_model dut=%h model=%h", dvec(), mvec());
    end
  endtask

  task automatic test_basic();
    logic [31:0] seq [4];
    seq = '{32'hA0000000, 32'hB0000000, 32'hA1000000, 32'hB1000000};
    settle();
    cyc(1, 1, 1, seq[0], 1, seq[1], 1);
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL basic_write_edge valid_out=%b required=0", bus.valid_out);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (i == 0) cyc(1, 1, 1, seq[2], 1, seq[3], 1);
      else        cyc(1, 1, 0, '0, 0, '0, 1);
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== seq[i]) begin
        failures++;
        $display("FAIL basic_seq[%0d] got v=%b d=%h required v=1 d=%h",
                 i, bus.valid_out, bus.data_out, seq[i]);
      end
      checks++;
      if (dvec() !== mvec()) begin
        failures++;
        $display("FAIL basic_model dut=%h model=%h", dvec(), mvec());
      end
    end
    cyc(1, 1, 0, '0, 0, '0, 1);
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain valid_out=%b required=0", bus.valid_out);
    end
  endtask

  task automatic test_skew();
    bit          v0, v1, ev;
    logic [31:0] d0, d1, ed;
    settle();
    for (int unsigned i = 0; i < 8; i++) begin
      v0 = (i == 3 || i == 4);
      d0 = (i == 3) ? 32'hA0000000 : 32'hA1000000;
      v1 = (i == 0 || i == 1);
      d1 = (i == 0) ? 32'hB0000000 : 32'hB1000000;
      ev = (i >= 4);
      case (i)
        4:       ed = 32'hA0000000;
        5:       ed = 32'hB0000000;
        6:       ed = 32'hA1000000;
        default: ed = 32'hB1000000;
      endcase
      cyc(1, 1, v0, d0, v1, d1, 1);
      checks++;
      if (bus.valid_out !== ev || (ev && bus.data_out !== ed) || bus.full1 !== 1'b0) begin
        failures++;
        $display("FAIL skew[%0d] got v=%b d=%h full1=%b required v=%b d=%h full1=0",
                 i, bus.valid_out, bus.data_out, bus.full1, ev, ed);
      end
      checks++;
      if (dvec() !== mvec()) begin
        failures++;
        $display("FAIL skew_model dut=%h model=%h", dvec(), mvec());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0 [4];
    logic [31:0] d1 [4];
    logic [31:0] expv [$];
    logic [31:0] obs [$];
    logic [31:0] held;
    bit          rdy, v, was_v;
    for (int unsigned i = 0; i < 4; i++) begin
      d0[i] = $urandom;
      d1[i] = $urandom;
      expv.push_back(d0[i]);
      expv.push_back(d1[i]);
    end
    settle();
    for (int unsigned c = 0; c < 20; c++) begin
      rdy = !(c >= 3 && c < 8);
      v   = (c < 4);
      if (bus.valid_out && rdy) obs.push_back(bus.data_out);
      held  = bus.data_out;
      was_v = bus.valid_out;
      cyc(1, 1, v, d0[c % 4], v, d1[c % 4], rdy);
      checks++;
      if (dvec() !== mvec()) begin
        failures++;
        $display("FAIL bp_model c=%0d dut=%h model=%h", c, dvec(), mvec());
      end
      if (!rdy && was_v) begin
        checks++;
        if (bus.valid_out !== 1'b1 || bus.data_out !== held) begin
          failures++;
          $display("FAIL bp_hold c=%0d got v=%b d=%h required v=1 d=%h",
                   c, bus.valid_out, bus.data_out, held);
        end
      end
    end
    checks++;
    if (obs.size() != 8) begin
      failures++;
      $display("FAIL bp_count got=%0d required=8", obs.size());
    end
    for (int unsigned i = 0; i < 8 && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== expv[i]) begin
        failures++;
        $display("FAIL bp_order[%0d] got=%h required=%h", i, obs[i], expv[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] prime;
    prime = 32'h5A5A0001;
    settle();
    cyc(1, 1, 1, prime, 0, '0, 0);
    for (int unsigned w = 1; w <= 5; w++) begin
      cyc(1, 1, 1, 32'hC0000000 + w, 0, '0, 0);
      checks++;
      if (dvec() !== mvec()) begin
        failures++;
        $display("FAIL ovf_model w=%0d dut=%h model=%h", w, dvec(), mvec());
      end
      if (w == 4) begin
        checks++;
        if (bus.full0 !== 1'b1 || bus.overflow_err !== 1'b0) begin
          failures++;
          $display("FAIL ovf_full_after4 full0=%b ovf=%b required full0=1 ovf=0",
                   bus.full0, bus.overflow_err);
        end
      end
      if (w == 5) begin
        checks++;
        if (bus.full0 !== 1'b1 || bus.overflow_err !== 1'b1) begin
          failures++;
          $display("FAIL ovf_drop5 full0=%b ovf=%b required full0=1 ovf=1",
                   bus.full0, bus.overflow_err);
        end
      end
    end
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(1, 1, 0, '0, 0, '0, 0);
      checks++;
      if (bus.overflow_err !== 1'b1 || bus.valid_out !== 1'b1 || bus.data_out !== prime) begin
        failures++;
        $display("FAIL ovf_sticky ovf=%b v=%b d=%h required ovf=1 v=1 d=%h",
                 bus.overflow_err, bus.valid_out, bus.data_out, prime);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] n0;
    n0 = 32'h1E5_0000;
    settle();
    cyc(1, 1, 1, 32'hF0000000, 1, 32'hE0000000, 0);
    cyc(1, 1, 1, 32'hF0000001, 1, 32'hE0000001, 0);
    cyc(1, 1, 1, 32'hF0000002, 0, '0, 0);
    checks++;
    if (dvec() !== mvec()) begin
      failures++;
      $display("FAIL flush_pre_model dut=%h model=%h", dvec(), mvec());
    end
    cyc(1, 0, 1, 32'hDEAD0000, 1, 32'hDEAD0001, 1);
    checks++;
    if (bus.valid_out !== 1'b0 || bus.full0 !== 1'b0 || bus.full1 !== 1'b0 ||
        bus.overflow_err !== 1'b1) begin
      failures++;
      $display("FAIL flush_state v=%b f0=%b f1=%b ovf=%b required v=0 f0=0 f1=0 ovf=1",
               bus.valid_out, bus.full0, bus.full1, bus.overflow_err);
    end
    cyc(1, 1, 0, '0, 0, '0, 1);
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_stale valid_out=%b required=0", bus.valid_out);
    end
    cyc(1, 1, 1, n0, 1, n0 + 1, 1);
    cyc(1, 1, 0, '0, 0, '0, 1);
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== n0 || bus.overflow_err !== 1'b1) begin
      failures++;
      $display("FAIL flush_first_new v=%b d=%h ovf=%b required v=1 d=%h ovf=1",
               bus.valid_out, bus.data_out, bus.overflow_err, n0);
    end
    checks++;
    if (dvec() !== mvec()) begin
      failures++;
      $display("FAIL flush_model dut=%h model=%h", dvec(), mvec());
    end
  endtask

  task automatic test_reset_mid();
    settle();
    cyc(1, 1, 1, 32'h11111111, 1, 32'h22222222, 0);
    cyc(1, 1, 1, 32'h33333333, 1, 32'h44444444, 0);
    cyc(0, 1, 1, 32'h55555555, 1, 32'h66666666, 1);
    checks++;
    if (dvec() !== 36'h0) begin
      failures++;
      $display("FAIL rstmid_outputs dut=%h required=%h", dvec(), 36'h0);
    end
`ifdef LANE_MERGE_CNT_EN
    checks++;
    if (bus.word_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_cnt0 word_cnt=%0d required=0", bus.word_cnt);
    end
`endif
    cyc(1, 1, 0, '0, 0, '0, 1);
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_no_partial valid_out=%b required=0", bus.valid_out);
    end
    cyc(1, 1, 1, 32'h70000000, 1, 32'h80000000, 1);
    cyc(1, 1, 1, 32'h70000001, 1, 32'h80000001, 1);
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 32'h70000000) begin
      failures++;
      $display("FAIL rstmid_first v=%b d=%h required v=1 d=70000000",
               bus.valid_out, bus.data_out);
    end
    for (int unsigned i = 0; i < 3; i++) cyc(1, 1, 0, '0, 0, '0, 1);
    checks++;
    if (dvec() !== mvec()) begin
      failures++;
      $display("FAIL rstmid_model dut=%h model=%h", dvec(), mvec());
    end
`ifdef LANE_MERGE_CNT_EN
    checks++;
    if (bus.word_cnt !== 16'd3) begin
      failures++;
      $display("FAIL rstmid_cnt3 word_cnt=%0d required=3", bus.word_cnt);
    end
`endif
  endtask

  task automatic test_random();
    bit r, e, v0, v1, rdy;
    for (int unsigned c = 0; c < 400; c++) begin
      r   = ($urandom_range(0, 99) != 0);
      e   = ($urandom_range(0, 24) != 0);
      v0  = ($urandom_range(0, 9) < 6);
      v1  = ($urandom_range(0, 9) < 6);
      rdy = ($urandom_range(0, 9) < 7);
      cyc(r, e, v0, $urandom, v1, $urandom, rdy);
      checks++;
      if (dvec() !== mvec()) begin
        failures++;
        $display("FAIL random_model c=%0d dut=%h model=%h", c, dvec(), mvec());
      end
`ifdef LANE_MERGE_CNT_EN
      checks++;
      if (bus.word_cnt !== m_cnt) begin
        failures++;
        $display("FAIL random_cnt c=%0d word_cnt=%0d model=%0d", c, bus.word_cnt, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew();
    test_backpressure();
    test_overflow();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
